// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, width helpers and mode enum for the programmable FIFO
package fifo_pkg;

  // Read-side behaviour selector
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: wraps naturally at depth-1 -> 0 for power-of-2 depths
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so the full count fits
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - push/pop handshake bundle between the FIFO and its producer/consumer
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  // Producer/consumer side
  modport master (
    output wr_en,
    output wr_data,
    output rd_en,
    input  rd_data,
    input  rd_valid
  );

  // FIFO side
  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, synchronous write and asynchronous read
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   FIFO_DEPTH = 16,
  localparam int  PTR_WIDTH  = ptr_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [PTR_WIDTH-1:0]  i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [PTR_WIDTH-1:0]  i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // Storage write; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds, level, flush and sticky errors
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  FIFO_DEPTH = 16,
  parameter int  FWFT       = 0,
  localparam int CNT_WIDTH  = cnt_width(FIFO_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  sync_fifo_prog_if.slave      bus,
  input  logic [CNT_WIDTH-1:0] i_almost_full_level,
  input  logic [CNT_WIDTH-1:0] i_almost_empty_level,
  input  logic                 i_error_clear,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_half_full,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [CNT_WIDTH-1:0] o_level,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_error
);

  localparam int                   PTR_WIDTH = ptr_width(FIFO_DEPTH);
  localparam fifo_mode_e           MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CNT_WIDTH-1:0] C_DEPTH   = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_HALF    = CNT_WIDTH'(FIFO_DEPTH / 2);

  logic [PTR_WIDTH-1:0]  r_wptr;
  logic [PTR_WIDTH-1:0]  r_rptr;
  logic [CNT_WIDTH-1:0]  r_level;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_do;
  logic                  w_wr_do;
  logic                  w_wr_drop;
  logic                  w_rd_drop;
  logic [DATA_WIDTH-1:0] w_ram_rd_data;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_DEPTH);

  // Flush swallows both requests, so nothing is accepted or flagged that cycle.
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign w_rd_do   = ~i_flush & bus.rd_en & ~w_empty;
  assign w_wr_do   = ~i_flush & bus.wr_en & (~w_full | w_rd_do);
  assign w_wr_drop = ~i_flush & bus.wr_en & ~w_wr_do;
  assign w_rd_drop = ~i_flush & bus.rd_en & w_empty;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_do),
    .i_wr_addr (r_wptr),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (r_rptr),
    .o_rd_data (w_ram_rd_data)
  );

  // Pointers and occupancy counter
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_do) r_wptr <= r_wptr + PTR_WIDTH'(1);
      if (w_rd_do) r_rptr <= r_rptr + PTR_WIDTH'(1);
      case ({w_wr_do, w_rd_do})
        2'b10:   r_level <= r_level + CNT_WIDTH'(1);
        2'b01:   r_level <= r_level - CNT_WIDTH'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags; a new error event wins over a simultaneous clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_drop)          r_overflow  <= 1'b1;
      else if (i_error_clear) r_overflow  <= 1'b0;
      if (w_rd_drop)          r_underflow <= 1'b1;
      else if (i_error_clear) r_underflow <= 1'b0;
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is presented directly; zero while nothing is stored
      assign bus.rd_data  = w_empty ? '0 : w_ram_rd_data;
      assign bus.rd_valid = ~w_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_valid;

      // Registered read: data appears the cycle after an accepted pop
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_do;
          if (w_rd_do) r_dout <= w_ram_rd_data;
        end
      end

      assign bus.rd_data  = r_dout;
      assign bus.rd_valid = r_valid;
    end
  endgenerate

  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_half_full    = (r_level >= C_HALF);
  assign o_almost_full  = (r_level >= i_almost_full_level);
  assign o_almost_empty = (r_level <= i_almost_empty_level);
  assign o_level        = r_level;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_error        = r_overflow | r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed self-checking bench for sync_fifo_prog in standard and FWFT modes
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] af_lvl;
  logic [3:0] ae_lvl;
  logic       err_clr;

  logic       s_empty, s_full, s_half, s_afull, s_aempty, s_ovf, s_unf, s_err;
  logic [3:0] s_level;
  logic       f_empty, f_full, f_half, f_afull, f_aempty, f_ovf, f_unf, f_err;
  logic [3:0] f_level;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_prog_if #(.DATA_WIDTH(8)) sb ();
  sync_fifo_prog_if #(.DATA_WIDTH(8)) fb ();

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0)) u_std (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_flush              (flush),
    .bus                  (sb.slave),
    .i_almost_full_level  (af_lvl),
    .i_almost_empty_level (ae_lvl),
    .i_error_clear        (err_clr),
    .o_empty              (s_empty),
    .o_full               (s_full),
    .o_half_full          (s_half),
    .o_almost_full        (s_afull),
    .o_almost_empty       (s_aempty),
    .o_level              (s_level),
    .o_overflow           (s_ovf),
    .o_underflow          (s_unf),
    .o_error              (s_err)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(1)) u_fwft (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_flush              (flush),
    .bus                  (fb.slave),
    .i_almost_full_level  (af_lvl),
    .i_almost_empty_level (ae_lvl),
    .i_error_clear        (err_clr),
    .o_empty              (f_empty),
    .o_full               (f_full),
    .o_half_full          (f_half),
    .o_almost_full        (f_afull),
    .o_almost_empty       (f_aempty),
    .o_level              (f_level),
    .o_overflow           (f_ovf),
    .o_underflow          (f_unf),
    .o_error              (f_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},  32'(s_level),  32'd0);
    check({tag, "_empty"},  32'(s_empty),  32'd1);
    check({tag, "_full"},   32'(s_full),   32'd0);
    check({tag, "_half"},   32'(s_half),   32'd0);
    check({tag, "_dout"},   32'(sb.rd_data), 32'h00);
    check({tag, "_valid"},  32'(sb.rd_valid), 32'd0);
    check({tag, "_ovf"},    32'(s_ovf),    32'd0);
    check({tag, "_unf"},    32'(s_unf),    32'd0);
    check({tag, "_err"},    32'(s_err),    32'd0);
    check({tag, "_aempty"}, 32'(s_aempty), 32'd1);
    check({tag, "_afull"},  32'(s_afull),  32'd0);
  endtask

  logic [7:0] exp3 [8];
  logic       fwft_seen;

  initial begin
    exp3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0;
    af_lvl = 4'd6; ae_lvl = 4'd2;
    sb.wr_en = 1'b0; sb.wr_data = 8'h00; sb.rd_en = 1'b0;
    fb.wr_en = 1'b0; fb.wr_data = 8'h00; fb.rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state, plus AlmostFull with a zero threshold
    check_reset_state("rst");
    af_lvl = 4'd0; #1;
    check("rst_afull_thr0", 32'(s_afull), 32'd1);
    af_lvl = 4'd6; #1;

    // 1: fill 01..08 then drain in order with one-cycle read latency
    for (int i = 1; i <= 8; i++) begin
      sb.wr_en = 1'b1; sb.wr_data = 8'(i);
      tick();
      check("t1_level", 32'(s_level), 32'(i));
    end
    sb.wr_en = 1'b0;
    check("t1_full", 32'(s_full), 32'd1);
    check("t1_half", 32'(s_half), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      sb.rd_en = 1'b1;
      tick();
      check("t1_dout",  32'(sb.rd_data),  32'(i));
      check("t1_valid", 32'(sb.rd_valid), 32'd1);
    end
    sb.rd_en = 1'b0;
    tick();
    check("t1_empty",    32'(s_empty),     32'd1);
    check("t1_valid_lo", 32'(sb.rd_valid), 32'd0);

    // 2: threshold flags while writing 7 words, then raise AlmostFullLevel
    for (int k = 1; k <= 7; k++) begin
      sb.wr_en = 1'b1; sb.wr_data = 8'(8'h10 + k - 1);
      tick();
      check("t2_aempty", 32'(s_aempty), (k <= 2) ? 32'd1 : 32'd0);
      check("t2_afull",  32'(s_afull),  (k >= 6) ? 32'd1 : 32'd0);
    end
    sb.wr_en = 1'b0;
    af_lvl = 4'd8; #1;
    check("t2_afull_thr8", 32'(s_afull), 32'd0);
    sb.wr_en = 1'b1; sb.wr_data = 8'h17;
    tick();
    sb.wr_en = 1'b0;
    check("t2_afull_lvl8", 32'(s_afull), 32'd1);
    af_lvl = 4'd9; #1;
    check("t2_afull_thr9", 32'(s_afull), 32'd0);
    af_lvl = 4'd6;

    // 3: write+read while full, then dropped write and error clear
    sb.wr_en = 1'b1; sb.wr_data = 8'hAA; sb.rd_en = 1'b1;
    tick();
    check("t3_level",  32'(s_level),   32'd8);
    check("t3_ovf0",   32'(s_ovf),     32'd0);
    check("t3_dout",   32'(sb.rd_data), 32'h10);
    sb.rd_en = 1'b0; sb.wr_data = 8'hBB;
    tick();
    sb.wr_en = 1'b0;
    check("t3_level_drop", 32'(s_level), 32'd8);
    check("t3_ovf1",       32'(s_ovf),   32'd1);
    check("t3_err1",       32'(s_err),   32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_ovf_clr", 32'(s_ovf), 32'd0);
    check("t3_err_clr", 32'(s_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      sb.rd_en = 1'b1;
      tick();
      check("t3_drain", 32'(sb.rd_data), 32'(exp3[i]));
    end
    sb.rd_en = 1'b0;
    tick();
    check("t3_empty", 32'(s_empty), 32'd1);

    // 4: underflow on empty, then simultaneous write+read on empty
    sb.rd_en = 1'b1;
    tick();
    check("t4_unf",   32'(s_unf),       32'd1);
    check("t4_valid", 32'(sb.rd_valid), 32'd0);
    check("t4_level", 32'(s_level),     32'd0);
    sb.rd_en = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_unf_clr", 32'(s_unf), 32'd0);
    sb.wr_en = 1'b1; sb.wr_data = 8'h5A; sb.rd_en = 1'b1;
    tick();
    sb.wr_en = 1'b0;
    check("t4_level1",  32'(s_level),     32'd1);
    check("t4_unf2",    32'(s_unf),       32'd1);
    check("t4_valid2",  32'(sb.rd_valid), 32'd0);
    tick();
    sb.rd_en = 1'b0;
    check("t4_dout", 32'(sb.rd_data), 32'h5A);
    check("t4_vld",  32'(sb.rd_valid), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // 5: first-word-fall-through instance
    fwft_seen = f_empty;
    check("t5_empty0", 32'(fwft_seen), 32'd1);
    check("t5_dout0",  32'(fb.rd_data), 32'h00);
    fb.wr_en = 1'b1; fb.wr_data = 8'h3C;
    tick();
    fb.wr_en = 1'b0;
    check("t5_dout",  32'(fb.rd_data),  32'h3C);
    check("t5_valid", 32'(fb.rd_valid), 32'd1);
    fb.rd_en = 1'b1;
    tick();
    fb.rd_en = 1'b0;
    check("t5_empty", 32'(f_empty),     32'd1);
    check("t5_dout2", 32'(fb.rd_data),  32'h00);
    check("t5_valid2",32'(fb.rd_valid), 32'd0);

    // 6: flush ignores a concurrent write and keeps sticky errors; reset restores all
    for (int i = 0; i < 4; i++) begin
      sb.wr_en = 1'b1; sb.wr_data = 8'(8'h61 + i);
      tick();
    end
    check("t6_level4", 32'(s_level), 32'd4);
    flush = 1'b1; sb.wr_data = 8'h99;
    tick();
    flush = 1'b0; sb.wr_en = 1'b0;
    check("t6_level0", 32'(s_level),     32'd0);
    check("t6_empty",  32'(s_empty),     32'd1);
    check("t6_dout",   32'(sb.rd_data),  32'h5A);
    check("t6_valid",  32'(sb.rd_valid), 32'd0);
    check("t6_ovf",    32'(s_ovf),       32'd0);
    for (int i = 0; i < 9; i++) begin
      sb.wr_en = 1'b1; sb.wr_data = 8'(8'h70 + i);
      tick();
    end
    sb.wr_en = 1'b0;
    check("t6_ovf_set", 32'(s_ovf), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_lvl", 32'(s_level), 32'd0);
    check("t6_flush_ovf", 32'(s_ovf),   32'd1);
    sb.wr_en = 1'b1; sb.wr_data = 8'h42;
    tick();
    sb.wr_en = 1'b0;
    sb.rd_en = 1'b1; rst = 1'b1;
    tick();
    sb.rd_en = 1'b0; rst = 1'b0;
    check_reset_state("t6_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised successor to the dual-clock FIFO. Adds programmable almost-full/almost-empty thresholds, an occupancy count, synchronous flush, and sticky overflow/underflow flags with clear. A FWFT parameter selects standard mode (registered read) or first-word-fall-through. It sits between producer and consumer blocks in the same clock domain.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1).
FIFO_DEPTH, 16, number of entries; power of 2, >=4.
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through.
CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of Level and the threshold ports (derived; not overridden).

Ports:
Clock  in  1  single clock; all state updates on posedge.
Reset  in  1  synchronous, active-high reset.
Flush  in  1  synchronous empty; no effect on sticky error flags.
WriteEn  in  1  push request.
DataIn  in  DATA_WIDTH  push data.
ReadEn  in  1  pop request.
DataOut  out  DATA_WIDTH  read data.
DataValid  out  1  standard mode: DataOut valid this cycle. FWFT mode: equals ~Empty.
Empty  out  1  Level==0.
Full  out  1  Level==FIFO_DEPTH.
HalfFull  out  1  Level>=FIFO_DEPTH/2.
AlmostFullLevel  in  CNT_WIDTH  almost-full threshold.
AlmostEmptyLevel  in  CNT_WIDTH  almost-empty threshold.
AlmostFull  out  1  Level>=AlmostFullLevel.
AlmostEmpty  out  1  Level<=AlmostEmptyLevel.
Level  out  CNT_WIDTH  current occupancy, 0..FIFO_DEPTH.
Overflow  out  1  sticky: a write was dropped.
Underflow  out  1  sticky: a read was rejected.
ErrorClear  in  1  clears Overflow and Underflow.
Error  out  1  Overflow|Underflow.

Behaviour:
- Clock domain: one clock; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: pointers=0, Level=0, Empty=1, Full=0, HalfFull=0, DataOut=0, DataValid=0, Overflow=0, Underflow=0. AlmostEmpty=1. AlmostFull=(AlmostFullLevel==0). Memory contents are not reset.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally at FIFO_DEPTH-1 -> 0. Level is a separate registered counter.
- All flags are combinational from the registered Level and the threshold ports, so they update the cycle after the accepted operation.
- Write is accepted iff WriteEn & (~Full | read accepted same cycle): mem[wptr]<=DataIn, wptr++.
- Read is accepted iff ReadEn & ~Empty: rptr++.
- Level update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with simultaneous write and read: both are accepted; Level stays FIFO_DEPTH.
- Empty with simultaneous write and read: the write is accepted, the read is rejected, Underflow is set, and Level becomes 1.
- Rejected write: data dropped, state unchanged, Overflow<=1.
- Rejected read: state unchanged, Underflow<=1. Standard mode also forces DataValid=0 next cycle.
- Standard mode: on an accepted read, DataOut<=mem[rptr] and DataValid<=1 on the next cycle (latency 1). Otherwise DataValid<=0 and DataOut holds its last value.
- FWFT mode: DataOut=mem[rptr] combinationally, forced to 0 while Empty. ReadEn acknowledges the shown word. Write-to-visible latency is 1 cycle (visible after Empty deasserts).
- Flush: pointers and Level <=0. WriteEn and ReadEn are ignored that cycle. DataValid<=0; DataOut holds in standard mode. Overflow and Underflow are kept.
- ErrorClear: clears both sticky flags. If an error event occurs in the same cycle, set wins.
- Thresholds may change at any time; the flags follow combinationally. AlmostFullLevel>FIFO_DEPTH means AlmostFull is never asserted.
- Reset mid-operation: any in-flight read is discarded; DataValid=0 the next cycle.

Decomposition:
- Package fifo_pkg holds shared constants and helpers: the CNT_WIDTH/pointer-width computation and an enum for the mode values (FIFO_STD=0, FIFO_FWFT=1).
- One natural sub-module: fifo_ram, a simple dual-port array with synchronous write, asynchronous read, and parameters DATA_WIDTH and FIFO_DEPTH.
- Control, Level, flags and sticky errors stay in sync_fifo_prog.

Test Plan:
1. FIFO_DEPTH=8, standard mode: write 01..08 -> Full=1, HalfFull=1, Level=8. Then read 8 times -> DataOut 01..08, each one cycle after ReadEn with DataValid=1; finally Empty=1.
2. Thresholds AlmostFullLevel=6, AlmostEmptyLevel=2: write 7 words. AlmostEmpty deasserts once Level=3; AlmostFull asserts once Level=6. Change AlmostFullLevel to 8 -> AlmostFull drops in the same cycle.
3. Full (8 words), write AA + read same cycle -> Level stays 8, Overflow=0. Lone write BB -> dropped, Overflow=1, Error=1. ErrorClear -> Overflow=0.
4. Empty, read only -> Underflow=1, DataValid=0. Empty with simultaneous write 5A + read -> Level=1, Underflow=1. Next read returns 5A.
5. FWFT=1: write 3C -> DataOut=3C and DataValid=1 one cycle later, before any ReadEn. ReadEn -> Empty=1 and DataOut=00 the next cycle.
6. Write 4 words, assert Flush together with WriteEn -> Level=0, Empty=1, write ignored. Assert Reset with Overflow=1 -> all outputs return to their reset values.
